// File: rtl/range_sensor_pkg.sv
// Shared types for the range-sensor echo timer.
// State encoding and the timeout sentinel word.
package range_sensor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    WRITE,
    HOLDOFF
  } ranger_state_t;

  function automatic logic [63:0] timeout_sentinel(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Echo pin synchronizer and registered edge detector.
// Both edges see the same 3-cycle delay.
module echo_sync (
  input  logic clk,
  input  logic rs,
  input  logic echo,
  output logic echo_s,
  output logic rise,
  output logic fall
);

  logic s1;
  logic prev;

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      s1     <= 1'b0;
      echo_s <= 1'b0;
      prev   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1     <= echo;
      echo_s <= s1;
      prev   <= echo_s;
      rise   <= echo_s & ~prev;
      fall   <= ~echo_s & prev;
    end
  end

endmodule

// File: rtl/echo_pulse_timer.sv
// Ultrasonic trigger/echo timer feeding a FIFO.
// Echo width in microseconds, all-ones on timeout.
module echo_pulse_timer
  import range_sensor_pkg::*;
#(
  parameter int DATA_WIDTH          = 16,
  parameter int US_DIV              = 100,
  parameter int TRIG_CYCLES         = 1000,
  parameter int RISE_TIMEOUT_CYCLES = 3_000_000,
  parameter int ECHO_MAX_US         = 30_000,
  parameter int HOLDOFF_CYCLES      = 6_000_000
) (
  input  logic                  clk,
  input  logic                  rs,
  input  logic                  en,
  input  logic                  echo,
  input  logic                  full,
  input  logic                  clr,
  output logic                  trig,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  overrun
);

  localparam int TW  = $clog2(TRIG_CYCLES);
  localparam int RW  = $clog2(RISE_TIMEOUT_CYCLES);
  localparam int HW  = $clog2(HOLDOFF_CYCLES);
  localparam int CW0 = (TW > RW) ? TW : RW;
  localparam int CW1 = (CW0 > HW) ? CW0 : HW;
  localparam int CW  = (CW1 < 1) ? 1 : CW1;
  localparam int PW  = $clog2(US_DIV);

  localparam logic [DATA_WIDTH-1:0] SENT =
    DATA_WIDTH'(timeout_sentinel(DATA_WIDTH));

  ranger_state_t         state;
  logic [CW-1:0]         cnt;
  logic [PW-1:0]         psc;
  logic [DATA_WIDTH-1:0] width;
  logic                  echo_s;
  logic                  rise;
  logic                  fall;

  echo_sync u_sync (
    .clk    (clk),
    .rs     (rs),
    .echo   (echo),
    .echo_s (echo_s),
    .rise   (rise),
    .fall   (fall)
  );

  logic                  wrap;
  logic [DATA_WIDTH-1:0] width_inc;
  logic                  at_max;
  logic                  fin;
  logic [DATA_WIDTH-1:0] fin_val;

  assign wrap      = (psc == PW'(US_DIV - 1));
  assign width_inc = width + DATA_WIDTH'(wrap);
  assign at_max    = echo_s
                   && (width_inc == DATA_WIDTH'(ECHO_MAX_US));

  // fin marks the cycle a result is decided; fall beats the max limit
  always_comb begin
    fin     = 1'b0;
    fin_val = SENT;
    unique case (1'b1)
      (state == WAIT_RISE) && !rise
        && (cnt == CW'(RISE_TIMEOUT_CYCLES - 1)): begin
        fin = 1'b1;
      end
      (state == MEASURE) && (fall || at_max): begin
        fin     = 1'b1;
        fin_val = fall ? width_inc : SENT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state   <= IDLE;
      cnt     <= '0;
      psc     <= '0;
      width   <= '0;
      trig    <= 1'b0;
      wr      <= 1'b0;
      wr_data <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      wr <= 1'b0;
      if (clr) overrun <= 1'b0;
      if (fin) begin
        if (full) begin
          overrun <= 1'b1;
        end else begin
          wr      <= 1'b1;
          wr_data <= fin_val;
        end
      end
      case (state)
        IDLE: begin
          if (en) begin
            state <= TRIG;
            trig  <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        TRIG: begin
          if (cnt == CW'(TRIG_CYCLES - 1)) begin
            trig  <= 1'b0;
            state <= WAIT_RISE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            state <= MEASURE;
            psc   <= '0;
            width <= '0;
          end else if (fin) begin
            state <= WRITE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEASURE: begin
          psc   <= wrap ? '0 : psc + 1'b1;
          width <= width_inc;
          if (fin) state <= WRITE;
        end
        WRITE: begin
          state <= HOLDOFF;
          cnt   <= '0;
        end
        HOLDOFF: begin
          if (cnt == CW'(HOLDOFF_CYCLES - 1)) begin
            cnt <= '0;
            if (en) begin
              state <= TRIG;
              trig  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
